// File: rtl/trace_serialiser.sv
// trace_serialiser
//   Buffers packed trace records in a small FIFO and streams each one out as
//   a sequence of 32-bit words, least-significant word first.
//
//   Optional feature: define GOURAM_TRACE_HEADER_EN to prefix every record
//   with a header word {16'hA5A5, seq[15:0]}. Here seq is a per-record
//   sequence number that wraps.
//
// Parameters
//   TRACE_WIDTH    width of one trace record (32..256)
//   FIFO_DEPTH     record buffer depth (power of two, >= 2)
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   trace_valid_i/_data_i     record offer from the trace unit
//   trace_ready_o             buffer not full (registered)
//   out_valid_o/_ready_i      output word handshake
//   out_data_o, out_last_o    serialised word, final-payload-word flag
//   records_sent_o            number of fully transmitted records (wraps)
module trace_serialiser #(
    parameter int TRACE_WIDTH = 96,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_valid_i,
    input  logic [TRACE_WIDTH-1:0] trace_data_i,
    output logic                   trace_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_data_o,
    output logic                   out_last_o,
    output logic [31:0]            records_sent_o
);
    localparam int NWORDS = (TRACE_WIDTH + 31) / 32;
    localparam int PADW   = NWORDS * 32;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    localparam logic [IDXW-1:0] LAST_IDX      = IDXW'(NWORDS - 1);
    localparam logic [IDXW-1:0] IDX_ZERO      = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE       = IDXW'(1);
    localparam logic [AW-1:0]   PTR_ONE       = AW'(1);
    localparam logic [CW-1:0]   CNT_ZERO      = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE       = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL      = CW'(FIFO_DEPTH);
    localparam logic            LAST_ON_FIRST = (NWORDS == 1);

`ifdef GOURAM_TRACE_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_t;
`endif

    // Word idx of a record, with the record zero-extended to a word multiple.
    function automatic logic [31:0] word_of(input logic [TRACE_WIDTH-1:0] rec,
                                            input logic [IDXW-1:0]        idx);
        logic [PADW-1:0] padded;
        padded = PADW'(rec);
        return padded[{idx, 5'd0} +: 32];
    endfunction

    state_t                 state_q, state_d, start_state_s;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [31:0]            sent_q, sent_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ready_q, ready_d;
    logic [TRACE_WIDTH-1:0] mem_q [FIFO_DEPTH];
`ifdef GOURAM_TRACE_HEADER_EN
    logic [15:0]            seq_q, seq_d;
`endif

    logic                   push_s, pop_s, hs_s, has_next_s, start_last_s;
    logic [TRACE_WIDTH-1:0] head_s, next_rec_s;
    logic [31:0]            start_word_s;

    // Handshakes and the record that follows the head. When only the head is
    // buffered, a record arriving in the same cycle is the next one, so the
    // last-word handshake can start it without a bubble (it still passes
    // through the output register first).
    always_comb begin
        push_s = trace_valid_i & ready_q;
        hs_s   = out_valid_q & out_ready_i;
        head_s = mem_q[rd_ptr_q];
        if (count_q > CNT_ONE) begin
            next_rec_s = mem_q[rd_ptr_q + PTR_ONE];
        end else begin
            next_rec_s = trace_data_i;
        end
        has_next_s = (count_q > CNT_ONE) | push_s;
    end

    // Serialiser FSM: next state and the next contents of the output register.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sent_d      = sent_q;
        pop_s       = 1'b0;
`ifdef GOURAM_TRACE_HEADER_EN
        seq_d         = seq_q;
        start_state_s = HDR;
        start_last_s  = 1'b0;
        // From SEND the record starting is the one after the popped head.
        if (state_q == IDLE) begin
            start_word_s = {16'hA5A5, seq_q};
        end else begin
            start_word_s = {16'hA5A5, seq_q + 16'd1};
        end
`else
        start_state_s = SEND;
        start_last_s  = LAST_ON_FIRST;
        if (state_q == IDLE) begin
            start_word_s = word_of(head_s, IDX_ZERO);
        end else begin
            start_word_s = word_of(next_rec_s, IDX_ZERO);
        end
`endif
        case (state_q)
            IDLE: begin
                if (count_q != CNT_ZERO) begin
                    state_d     = start_state_s;
                    idx_d       = IDX_ZERO;
                    out_valid_d = 1'b1;
                    out_data_d  = start_word_s;
                    out_last_d  = start_last_s;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef GOURAM_TRACE_HEADER_EN
            HDR: begin
                if (hs_s) begin
                    state_d    = SEND;
                    idx_d      = IDX_ZERO;
                    out_data_d = word_of(head_s, IDX_ZERO);
                    out_last_d = LAST_ON_FIRST;
                end else begin
                    state_d = HDR;
                end
            end
`endif
            SEND: begin
                if (hs_s) begin
                    if (idx_q == LAST_IDX) begin
                        pop_s  = 1'b1;
                        sent_d = sent_q + 32'd1;
`ifdef GOURAM_TRACE_HEADER_EN
                        seq_d  = seq_q + 16'd1;
`endif
                        if (has_next_s) begin
                            state_d     = start_state_s;
                            idx_d       = IDX_ZERO;
                            out_valid_d = 1'b1;
                            out_data_d  = start_word_s;
                            out_last_d  = start_last_s;
                        end else begin
                            state_d     = IDLE;
                            idx_d       = IDX_ZERO;
                            out_valid_d = 1'b0;
                            out_data_d  = 32'd0;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        out_data_d = word_of(head_s, idx_q + IDX_ONE);
                        out_last_d = ((idx_q + IDX_ONE) == LAST_IDX);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d     = IDLE;
                idx_d       = IDX_ZERO;
                out_valid_d = 1'b0;
                out_data_d  = 32'd0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointers and occupancy; ready reflects the post-update occupancy,
    // so a pop in the same cycle never lets a push into a full buffer.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_FULL);
    end

    // Control, output and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= IDX_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
            sent_q      <= 32'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= CNT_ZERO;
            ready_q     <= 1'b0;
`ifdef GOURAM_TRACE_HEADER_EN
            seq_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sent_q      <= sent_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
`ifdef GOURAM_TRACE_HEADER_EN
            seq_q       <= seq_d;
`endif
        end
    end

    // Record storage; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    assign trace_ready_o  = ready_q;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_last_o     = out_last_q;
    assign records_sent_o = sent_q;
endmodule

// File: tb/tb_trace_serialiser.sv
// Testbench for trace_serialiser: directed cases plus randomized traffic,
// checked word by word against a queue-based reference model.
module tb_trace_serialiser;
    localparam int TW    = 96;
    localparam int DEPTH = 4;
    localparam int NW    = 3;
`ifdef GOURAM_TRACE_HEADER_EN
    localparam int HW = 1;
`else
    localparam int HW = 0;
`endif

    logic          clk, rst;
    logic          trace_valid_i, trace_ready_o, out_valid_o, out_ready_i, out_last_o;
    logic [TW-1:0] trace_data_i;
    logic [31:0]   out_data_o, records_sent_o;

    logic          v80, rdy80, ov80, ordy80, ol80;
    logic [79:0]   d80;
    logic [31:0]   od80, sent80;

    trace_serialiser #(.TRACE_WIDTH(TW), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .trace_valid_i(trace_valid_i), .trace_data_i(trace_data_i),
        .trace_ready_o(trace_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o),
        .records_sent_o(records_sent_o)
    );

    trace_serialiser #(.TRACE_WIDTH(80), .FIFO_DEPTH(DEPTH)) u_dut80 (
        .clk(clk), .rst(rst),
        .trace_valid_i(v80), .trace_data_i(d80),
        .trace_ready_o(rdy80),
        .out_valid_o(ov80), .out_ready_i(ordy80),
        .out_data_o(od80), .out_last_o(ol80),
        .records_sent_o(sent80)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every accepted record expands into its word list.
    logic [32:0] exp_q[$];   // {last, data}
    int          occ       = 0;
    logic [15:0] m_seq     = 16'd0;
    logic [31:0] m_sent    = 32'd0;
    logic        ready_exp = 1'b0;
    bit          prev_stall = 1'b0;
    int          cyc       = 0;
    logic [31:0] log_w[$];
    int          log_c[$];
    logic        log_l[$];

    task automatic model_push(input logic [TW-1:0] rec);
        if (HW == 1) begin
            exp_q.push_back({1'b0, 16'hA5A5, m_seq});
            m_seq = m_seq + 16'd1;
        end
        for (int k = 0; k < NW; k++) begin
            exp_q.push_back({(k == NW - 1), 32'(rec >> (32 * k))});
        end
    endtask

    // Monitor: sample away from the rising edge and compare with the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                occ = 0; m_seq = 16'd0; m_sent = 32'd0;
                ready_exp = 1'b0; prev_stall = 1'b0;
            end else begin
                check_val("trace_ready", 64'(trace_ready_o), 64'(ready_exp));
                check_val("records_sent", 64'(records_sent_o), 64'(m_sent));
                if (prev_stall) check_val("hold_valid", 64'(out_valid_o), 64'd1);
                if (exp_q.size() == 0) begin
                    check_val("spurious_valid", 64'(out_valid_o), 64'd0);
                end else if (out_valid_o) begin
                    check_val("out_data", 64'(out_data_o), 64'(exp_q[0][31:0]));
                    check_val("out_last", 64'(out_last_o), 64'(exp_q[0][32]));
                end
                prev_stall = out_valid_o && !out_ready_i;
                if (out_valid_o && out_ready_i && exp_q.size() > 0) begin
                    log_w.push_back(out_data_o);
                    log_c.push_back(cyc);
                    log_l.push_back(out_last_o);
                    if (exp_q[0][32]) begin
                        m_sent = m_sent + 32'd1;
                        occ--;
                    end
                    void'(exp_q.pop_front());
                end
                if (trace_valid_i && trace_ready_o) begin
                    model_push(trace_data_i);
                    occ++;
                end
                ready_exp = (occ < DEPTH);
            end
            cyc++;
        end
    end

    task automatic clear_log();
        log_w.delete(); log_c.delete(); log_l.delete();
    endtask

    task automatic push_rec(input logic [TW-1:0] rec);
        trace_valid_i = 1'b1;
        trace_data_i  = rec;
        @(posedge clk); #1;
        trace_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid_o) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check_val({tag, "_data"},  64'(out_data_o), 64'd0);
        check_val({tag, "_last"},  64'(out_last_o), 64'd0);
        check_val({tag, "_ready"}, 64'(trace_ready_o), 64'd0);
        check_val({tag, "_sent"},  64'(records_sent_o), 64'd0);
    endtask

    logic [31:0] e34 [4];
    logic [31:0] w80 [4];
    logic        l80 [4];

    initial begin
        int n;
        rst = 1'b1; trace_valid_i = 1'b0; trace_data_i = '0; out_ready_i = 1'b0;
        v80 = 1'b0; d80 = '0; ordy80 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("rst");
        check_val("rst_ready80", 64'(rdy80), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_rst", 64'(trace_ready_o), 64'd1);

        // Single record, always-ready sink
        out_ready_i = 1'b1;
        clear_log();
        push_rec({32'h0000000C, 32'h0000000B, 32'h0000000A});
        wait_drain("t034_drain");
        if (HW == 1) begin
            e34[0] = 32'hA5A50000; e34[1] = 32'hA; e34[2] = 32'hB; e34[3] = 32'hC;
        end else begin
            e34[0] = 32'hA; e34[1] = 32'hB; e34[2] = 32'hC; e34[3] = 32'h0;
        end
        check_val("t034_nwords", 64'(log_w.size()), 64'(NW + HW));
        for (int i = 0; i < NW + HW && i < log_w.size(); i++) begin
            check_val("t034_word", 64'(log_w[i]), 64'(e34[i]));
            check_val("t034_last", 64'(log_l[i]), 64'(i == NW + HW - 1));
            check_val("t034_cycle", 64'(log_c[i] - log_c[0]), 64'(i));
        end
        @(posedge clk); #1;
        check_val("t034_sent", 64'(records_sent_o), 64'd1);

        // Second record: header sequence advances
        clear_log();
        push_rec({32'h0000000C, 32'h0000000B, 32'h0000000A});
        wait_drain("t035_drain");
        check_val("t035_first", 64'(log_w.size() > 0 ? log_w[0] : 32'hDEADBEEF),
                  (HW == 1) ? 64'hA5A50001 : 64'hA);

        // Fill with sink stalled, then drain
        out_ready_i = 1'b0;
        clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            push_rec({32'h0C + 32'(16 * i), 32'h0B + 32'(16 * i), 32'h0A + 32'(16 * i)});
        end
        @(negedge clk);
        check_val("t036_full", 64'(trace_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("t036_hold_valid", 64'(out_valid_o), 64'd1);
            check_val("t036_hold_data", 64'(out_data_o), (HW == 1) ? 64'hA5A50002 : 64'hA);
        end
        @(posedge clk); #1 out_ready_i = 1'b1;
        wait_drain("t036_drain");
        check_val("t036_nwords", 64'(log_w.size()), 64'(DEPTH * (NW + HW)));
        for (int i = 0; i < log_c.size(); i++) begin
            check_val("t036_no_bubble", 64'(log_c[i] - log_c[0]), 64'(i));
        end

        // Reset between second and third payload word
        clear_log();
        push_rec({32'h33, 32'h22, 32'h11});
        n = 0;
        while (log_w.size() < 2 + HW && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("t038_reach", 64'(log_w.size()), 64'(2 + HW));
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("t038_rst");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        clear_log();
        push_rec({32'h66, 32'h55, 32'h44});
        wait_drain("t038_drain");
        check_val("t038_nwords", 64'(log_w.size()), 64'(NW + HW));
        check_val("t038_first", 64'(log_w.size() > 0 ? log_w[0] : 32'hDEADBEEF),
                  (HW == 1) ? 64'hA5A50000 : 64'h44);
        @(posedge clk); #1;
        check_val("t038_sent", 64'(records_sent_o), 64'd1);

        // Randomized traffic with alternating sink pressure
        for (int c = 0; c < 3000; c++) begin
            trace_valid_i = ($urandom_range(0, 1) == 1);
            trace_data_i  = {$urandom, $urandom, $urandom};
            out_ready_i   = ($urandom_range(0, 9) < ((((c / 300) % 2) == 1) ? 2 : 8));
            @(posedge clk); #1;
        end
        trace_valid_i = 1'b0;
        out_ready_i   = 1'b1;
        wait_drain("rand_drain");

        // 80-bit record: final word zero-padded
        v80 = 1'b1; d80 = '1;
        @(posedge clk); #1 v80 = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < NW + HW; c++) begin
            @(negedge clk);
            if (ov80) begin
                w80[n] = od80;
                l80[n] = ol80;
                n++;
            end
        end
        check_val("t037_nwords", 64'(n), 64'(NW + HW));
        if (n == NW + HW) begin
            check_val("t037_w0", 64'(w80[HW]), 64'hFFFFFFFF);
            check_val("t037_w1", 64'(w80[HW + 1]), 64'hFFFFFFFF);
            check_val("t037_w2", 64'(w80[HW + 2]), 64'h0000FFFF);
            check_val("t037_last1", 64'(l80[HW + 1]), 64'd0);
            check_val("t037_last2", 64'(l80[HW + 2]), 64'd1);
        end
        @(posedge clk); #1;
        check_val("t037_sent", 64'(sent80), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/trace_serialiser.md
TRACE_SERIALISER -- requirements
Module: trace_serialiser

Interface
REQ-001 SHALL have parameter TRACE_WIDTH, default 96: width in bits of one packed trace record; legal range 32..256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: record buffer depth; power of two, at least 2.
REQ-003 SHALL define derived constant NWORDS = ceil(TRACE_WIDTH/32).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 trace_valid_i  input  1  a trace record is offered.
REQ-007 trace_data_i  input  TRACE_WIDTH  packed trace record from the trace unit.
REQ-008 trace_ready_o  output  1  record buffer can accept a record.
REQ-009 out_valid_o  output  1  out_data_o holds a valid word.
REQ-010 out_ready_i  input  1  downstream accepts the word.
REQ-011 out_data_o  output  32  serialised word.
REQ-012 out_last_o  output  1  current word is the final word of a record.
REQ-013 records_sent_o  output  32  count of fully transmitted records.

Function
REQ-014 SHALL accept a record on any cycle where trace_valid_i and trace_ready_o are both high.
REQ-015 SHALL drive trace_ready_o high exactly when the FIFO is not full, independent of trace_valid_i.
REQ-016 SHALL not accept a push when full, even if a record completes transmission in the same cycle.
REQ-017 SHALL store records in FIFO order; records are never dropped or reordered.
REQ-018 SHALL use a state machine with states IDLE, HDR, and SEND.
REQ-019 IDLE -> HDR when the FIFO is non-empty and the header is enabled; otherwise IDLE -> SEND.
REQ-020 HDR -> SEND on an output handshake (out_valid_o and out_ready_i both high).
REQ-021 SEND -> IDLE on the handshake of word NWORDS-1.
REQ-022 SHALL send the payload least-significant word first: word k = trace_data_i[32k+31:32k]; bits beyond TRACE_WIDTH in the final word are zero.
REQ-023 SHALL raise out_last_o only on payload word NWORDS-1.
REQ-024 SHALL register outputs; a record pushed in cycle t SHALL produce out_valid_o no earlier than cycle t+1 (no combinational bypass).
REQ-025 SHALL hold out_data_o and out_last_o stable while out_valid_o is high and out_ready_i is low, and keep out_valid_o high until the handshake.
REQ-026 Back-to-back: after a last-word handshake with the FIFO still non-empty, the next record's first word SHALL be valid in the next cycle (no bubble).
REQ-027 SHALL pop the FIFO on the last-word handshake, in the same cycle, and increment records_sent_o, which wraps at 2^32-1 -> 0.
REQ-028 Simultaneous push and pop when not full SHALL leave occupancy unchanged.

Reset
REQ-029 On rst high: state IDLE, FIFO empty, word index 0, sequence counter 0, records_sent_o 0, out_valid_o 0, out_data_o 0, out_last_o 0, trace_ready_o 0.
REQ-030 trace_ready_o SHALL go high on the first clock edge after rst deasserts.
REQ-031 Reset during a record SHALL discard that record and all buffered records; transmission SHALL NOT resume partway through a record.

Configuration
REQ-032 Macro GOURAM_TRACE_HEADER_EN defined: before each record's payload, SHALL emit one header word {16'hA5A5, seq[15:0]}; out_last_o is 0 on the header; seq starts at 0, increments per completed record and wraps 16'hFFFF -> 0.
REQ-033 Macro GOURAM_TRACE_HEADER_EN undefined: state HDR and the sequence counter SHALL be absent; records are NWORDS words with no header.

Verification
REQ-034 Header off, TRACE_WIDTH=96, out_ready_i=1, push 0x0000000C_0000000B_0000000A -> words 0xA, 0xB, 0xC on consecutive cycles; out_last_o high only with 0xC; records_sent_o becomes 1.
REQ-035 Header on, same record -> words 0xA5A50000, 0xA, 0xB, 0xC; the second record's header is 0xA5A50001.
REQ-036 out_ready_i=0, push 4 records (FIFO_DEPTH=4) -> trace_ready_o low after the 4th push; out_data_o holds 0xA stable; raising out_ready_i then drains 12 words in order with no bubbles.
REQ-037 TRACE_WIDTH=80, record with all bits set -> third word is 0x0000FFFF.
REQ-038 rst pulsed between the second and third word of a record -> all outputs 0, FIFO empty; a fresh record is then sent from word 0.
REQ-039 Header on, 65537 records -> the last header is 0xA5A50000.
